// File: rtl/input_port.sv
// Switch input port: two-flop synchroniser, debouncer and read handshake.
// Optional change-pulse output enabled by defining INPUT_PORT_IRQ_EN.
//
// Ports:
//   clock    - system clock, rising edge
//   n_reset  - synchronous reset, active low
//   switches - raw asynchronous switch bus
//   RE       - read enable, sampled on clock edge
//   Rdata    - registered read data (debounced word)
//   ready    - debounced word changed and not yet read
//   irq      - one-cycle change pulse (tied 0 without INPUT_PORT_IRQ_EN)
module input_port #(
  parameter int WORD_W     = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] switches,
  input  logic              RE,
  output logic [WORD_W-1:0] Rdata,
  output logic              ready,
  output logic              irq
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [WORD_W-1:0] s1_q, s1_d;
  logic [WORD_W-1:0] s2_q, s2_d;
  logic [WORD_W-1:0] cand_q, cand_d;
  logic [WORD_W-1:0] deb_q, deb_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              upd;

  // Debounce: candidate must match the synchronised word for
  // DEB_CYCLES-1 counted edges before it is accepted.
  always_comb begin
    s1_d   = switches;
    s2_d   = s1_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    upd    = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (cand_q != deb_q) begin
      deb_d = cand_q;
      upd   = 1'b1;
    end
  end

  // Read returns the pre-update word; a same-edge update keeps ready set.
  always_comb begin
    rdata_d = rdata_q;
    if (RE) rdata_d = deb_q;
    ready_d = upd | (ready_q & ~RE);
  end

  always_ff @(posedge clock) begin
    if (!n_reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      deb_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cand_q  <= cand_d;
      deb_q   <= deb_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign Rdata = rdata_q;
  assign ready = ready_q;

`ifdef INPUT_PORT_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = upd;

  always_ff @(posedge clock) begin
    if (!n_reset) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
